// File: rtl/lsu_mem_initiator_if.sv
// Request/response and data-memory pins of the MEM-stage load/store unit.
// master = the LSU (initiator), slave = pipeline + data memory side.
interface lsu_mem_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              busy;
  logic              mem_we;
  logic [2:0]        mem_mode;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, busy,
           mem_we, mem_mode, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, busy,
           mem_we, mem_mode, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator: aligned accesses in one cycle, misaligned ones split into bytes.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests are refused with misalign_err instead of split.
module lsu_mem_initiator #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic clk,
  input  logic rst,
  lsu_mem_initiator_if.master bus
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic misalign_err
`endif
);
  typedef enum logic {S_IDLE, S_SPLIT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   asm_q, asm_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              err_q, err_d;
`endif

  logic              req_ok, req_mis;
  logic [XLEN-1:0]   asm_next;
  logic [7:0]        wbyte;
  logic              mem_we;
  logic [2:0]        mem_mode;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;

  // Extension always comes from the low bits; the memory's own sign extension is ignored.
  function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3)
      3'b000:  extend = {{24{d[7]}}, d[7:0]};
      3'b001:  extend = {{16{d[15]}}, d[15:0]};
      3'b010:  extend = d;
      3'b100:  extend = {24'h0, d[7:0]};
      3'b101:  extend = {16'h0, d[15:0]};
      default: extend = '0;
    endcase
  endfunction

  always_comb begin
    if (bus.req_we) req_ok = !bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'b11);
    else            req_ok = (bus.req_funct3[1:0] != 2'b11) && (bus.req_funct3 != 3'b110);
    req_mis = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
              ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    asm_d        = asm_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
`ifdef LSU_MISALIGN_TRAP_EN
    err_d        = 1'b0;
`endif
    mem_we       = 1'b0;
    mem_mode     = 3'b010;
    mem_addr     = '0;
    mem_wdata    = '0;

    asm_next = asm_q;
    asm_next[{cnt_q, 3'b000} +: 8] = bus.mem_rdata[7:0];
    case (cnt_q)
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (!req_ok) begin
            resp_valid_d = 1'b1;
          end else if (!req_mis) begin
            mem_we       = bus.req_we;
            mem_mode     = {1'b0, bus.req_funct3[1:0]};
            mem_addr     = bus.req_addr;
            mem_wdata    = bus.req_wdata;
            resp_valid_d = 1'b1;
            resp_rdata_d = bus.req_we ? '0 : extend(bus.req_funct3, bus.mem_rdata);
          end else begin
`ifdef LSU_MISALIGN_TRAP_EN
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
`else
            state_d  = S_SPLIT;
            cnt_d    = 2'd0;
            last_d   = bus.req_funct3[1] ? 2'd3 : 2'd1;
            we_d     = bus.req_we;
            funct3_d = bus.req_funct3;
            addr_d   = bus.req_addr;
            wdata_d  = bus.req_wdata;
            asm_d    = '0;
`endif
          end
        end
      end
      S_SPLIT: begin
        mem_we    = we_q;
        mem_mode  = 3'b000;
        mem_addr  = addr_q + ADDR_W'(cnt_q);
        mem_wdata = we_q ? {24'h0, wbyte} : '0;
        if (!we_q) asm_d = asm_next;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == last_q) begin
          state_d      = S_IDLE;
          cnt_d        = 2'd0;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? '0 : extend(funct3_q, asm_next);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      last_q       <= 2'd0;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      asm_q        <= asm_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q        <= err_d;
`endif
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_we     = mem_we;
  assign bus.mem_mode   = mem_mode;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_err   = err_q;
`endif
endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit in the MEM stage. It is the initiator side of the data-memory interface.
- Takes a RISC-V load/store request (funct3, address, store data) and drives the data memory's write enable, mode, address and write-data pins.
- Returns correctly extended load data with a one-cycle registered response.
- Misaligned halfword/word accesses are split into sequential byte accesses; req_ready stalls the pipeline while this happens.

Parameters:
- ADDR_W, 32, address width; also the wrap modulus for byte-split addressing.
- XLEN, 32, data width. Must be 32.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present this cycle
- req_ready  out  1  unit can accept a request (state IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB/SH/SW 000/001/010)
- req_addr  in  ADDR_W  effective byte address
- req_wdata  in  XLEN  store data, right-aligned
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  XLEN  extended load data; 0 for stores and invalid requests
- busy  out  1  state != IDLE
- mem_we  out  1  data-memory write enable
- mem_mode  out  3  000 byte, 001 halfword, 010 word
- mem_addr  out  ADDR_W  data-memory byte address
- mem_wdata  out  XLEN  data-memory write data
- mem_rdata  in  XLEN  data-memory asynchronous read data; byte/half modes arrive sign-extended

Behaviour:
- Memory contract: read is combinational within the cycle; write commits on clk rising edge when mem_we=1.
- Idle bus: mem_we=0, mem_mode=010, mem_addr=0, mem_wdata=0.
- Reset values: state=IDLE, cnt=0, resp_valid=0, resp_rdata=0, assembly register=0; busy=0, req_ready=1.
- Alignment classification:
  - Misaligned = halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Byte accesses are always aligned.
- Invalid requests:
  - Loads with funct3 011/110/111; stores with funct3[2]=1 or 011.
  - No memory access (mem_we=0). resp_valid=1 next cycle with rdata=0.
- IDLE, req_valid with an aligned valid request:
  - mem_* driven combinationally from the request in the same cycle. mem_mode=funct3[1:0] zero-padded.
  - mem_we=req_we.
  - Load data is captured at the edge. resp_valid=1 and resp_rdata valid in the following cycle.
  - Remain in IDLE; back-to-back requests sustain 1 per cycle.
- IDLE, req_valid with a misaligned valid request:
  - Latch we/funct3/addr/wdata. Set N=2 (half) or 4 (word). Go to SPLIT with cnt=0.
  - No memory access in the accept cycle.
- SPLIT:
  - req_ready=0. Each cycle: mem_mode=000, mem_addr=addr+cnt (wraps mod 2^ADDR_W).
  - Stores: mem_we=1, mem_wdata={24'b0, wdata[8cnt+7:8cnt]}.
  - Loads: mem_we=0; mem_rdata[7:0] is stored into assembly byte cnt.
  - cnt++. At cnt=N-1, return to IDLE; resp_valid next cycle.
  - Total latency: N+1 cycles from accept to resp_valid.
- Extension is done by the unit from the low bits; it never relies on the memory's sign extension:
  - LB: sign-extend bit 7. LBU: zero-extend [7:0].
  - LH: sign-extend bit 15. LHU: zero-extend [15:0].
  - LW: pass through.
- Timing rules:
  - resp_valid is high exactly one cycle per accepted request.
  - req_valid while req_ready=0 is ignored; the requester must hold the request.
- Reset mid-SPLIT: immediate return to IDLE, mem_we=0, no response. Bytes already written stay written.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misalign_err (1 bit, reset 0).
  - A misaligned request performs no memory access and does not enter SPLIT.
  - Next cycle: resp_valid=1, misalign_err=1 (one cycle), resp_rdata=0.
- Undefined: port absent; misaligned requests are byte-split as above.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF; then LW 0x10 → mem_we=1 mode 010 on the store cycle; load resp_rdata=0xDEADBEEF one cycle later.
- Memory byte 0x20=0x80: LB 0x20 → 0xFFFFFF80; LBU 0x20 → 0x00000080; LHU 0x20 with byte 0x21=0x00 → 0x00000080.
- SW 0x13 wdata 0x11223344 (split) → byte writes 0x44@0x13, 0x33@0x14, 0x22@0x15, 0x11@0x16 over 4 cycles; req_ready=0 throughout; resp_valid in cycle 5. LW 0x13 → 0x11223344.
- LH 0x21 with bytes 0x21=0xFE, 0x22=0xFF → 2 byte reads; resp_rdata=0xFFFFFFFE at cycle 3.
- Assert rst during cycle 2 of split SW 0x31 → no further mem_we, resp_valid never pulses, req_ready=1. With LSU_MISALIGN_TRAP_EN defined, the same SW → no writes; misalign_err=1 for one cycle with resp_valid.
- Load funct3=011 → mem_we=0; resp_valid next cycle, rdata=0. Back-to-back aligned LW 0x0, 0x4, 0x8 → three consecutive resp_valid pulses.
